radix_mul_arbiter: RTL
======================

# radix_mul_arbiter

Round-robin arbiter/scheduler that shares one radix-4 Booth multiplier core (signed WIDTH×WIDTH → 2·WIDTH, start/ready protocol) among N_REQ requesters. It sits between the requesters and the multiplier core, and drives the core's operand and start inputs. It accepts one operation at a time, waits for the core's ready pulse, and returns the signed product tagged with the requester index. A watchdog aborts an operation whose ready never arrives.

## Interface
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 8, operand width; result width is 2·WIDTH
- TIMEOUT, 64, max cycles spent in WAIT before abort (≥2)
- IDW, derived, max(1, $clog2(N_REQ))

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  request pending, per requester
- req_x  in  N_REQ×WIDTH  signed multiplicand, per requester
- req_y  in  N_REQ×WIDTH  signed multiplier, per requester
- req_ready  out  N_REQ  one-hot accept (combinational)
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  IDW  index of served requester
- rsp_result  out  2·WIDTH  signed product
- rsp_error  out  1  timeout flag, valid with rsp_valid
- mul_x, mul_y  out  WIDTH  operands to core, registered
- mul_start  out  1  one-cycle start pulse to core
- mul_ready  in  1  core done pulse
- mul_result  in  2·WIDTH  core product, valid with mul_ready

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant = first set req_valid bit searching from ptr upward, wrapping modulo N_REQ. req_ready[grant] = 1 only in IDLE, all other bits 0. A transfer occurs at the edge where req_valid[i] & req_ready[i]; latch x, y and id, then go to ISSUE. With no request, stay in IDLE.
- Requesters hold valid/operands until accepted. Dropping valid before accept is legal and no transfer occurs.
- ISSUE: mul_start = 1 for exactly this cycle; mul_x/mul_y are stable from ISSUE through WAIT. Clear the watchdog counter, then go to WAIT.
- WAIT: on mul_ready, capture mul_result, set error = 0 and go to RESP. If the counter reaches TIMEOUT−1 without mul_ready, set result = 0, error = 1 and go to RESP. mul_ready and timeout in the same cycle: mul_ready wins.
- RESP: rsp_valid = 1 with rsp_id, rsp_result and rsp_error for this one cycle. Set ptr = (id+1) mod N_REQ, then go to IDLE.
- mul_ready outside WAIT is ignored.
- Result is passed through unmodified. The arbiter does no arithmetic on the data path.

## Timing
- Reset values: state IDLE, ptr 0, counter 0. Every output is 0, including req_ready (forced 0 during reset), rsp_*, mul_x, mul_y and mul_start.
- Reset mid-operation aborts the operation immediately. No response is emitted and no mul_start follows.
- Accept at edge k: mul_start high in cycle k+1.
- If the core's ready arrives L cycles after start (L≥1), rsp_valid is high in cycle k+1+L+1.
- Next accept is possible in the RESP→IDLE cycle after that. Throughput: one operation per L+3 cycles.
- Timeout response: rsp_valid in cycle k+1+TIMEOUT+1.
- Fairness: a continuously requesting requester is served within N_REQ operations.

## Structure
- Package radix_arb_pkg holds:
  - state enum type: IDLE, ISSUE, WAIT, RESP
  - default WIDTH, N_REQ and TIMEOUT constants
- Sub-module radix_rr_pick: purely combinational rotate-priority picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, binary grant index and an any flag.
- The FSM, operand/ID registers and watchdog counter live in radix_mul_arbiter.

## Test plan
- Single request: requester 0 sends x=8'hFA (−6), y=8'h02, bench core latency L=4 → mul_start one cycle after accept, then rsp_valid with id=0, result=16'hFFF4 (−12), error=0, 6 cycles after accept.
- All four requesters valid continuously, each with distinct operands → grants in order 0,1,2,3,0; each result is the correct signed product, e.g. (−128)×(−128)=16'h4000 and 127×(−1)=16'hFF81.
- Rotation from ptr: after serving id=2, requesters 1 and 3 both request → id 3 is granted first, then id 1.
- Core never returns mul_ready → rsp_valid with error=1, result=0 exactly TIMEOUT+1 cycles after mul_start. The next request is then served normally.
- Reset asserted while in WAIT → all outputs 0 asynchronously, and no rsp_valid after release. A stray mul_ready in IDLE after release is ignored.
- mul_ready in the same cycle the counter reaches TIMEOUT−1 → error=0 and the core result is returned.

Source files
------------

// File: rtl/radix_arb_pkg.sv
// Shared types and default sizing for the round-robin multiplier arbiter.
package radix_arb_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

endpackage

// File: rtl/radix_mul_arbiter_if.sv
// Requester, response and multiplier-core signals of the arbiter.
interface radix_mul_arbiter_if
    import radix_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][WIDTH-1:0] req_x;
    logic [N_REQ-1:0][WIDTH-1:0] req_y;
    logic [N_REQ-1:0]            req_ready;

    logic                        rsp_valid;
    logic [IDW-1:0]              rsp_id;
    logic [2*WIDTH-1:0]          rsp_result;
    logic                        rsp_error;

    logic [WIDTH-1:0]            mul_x;
    logic [WIDTH-1:0]            mul_y;
    logic                        mul_start;
    logic                        mul_ready;
    logic [2*WIDTH-1:0]          mul_result;

    modport slave (
        input  req_valid, req_x, req_y, mul_ready, mul_result,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_error,
               mul_x, mul_y, mul_start
    );

    modport master (
        output req_valid, req_x, req_y, mul_ready, mul_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_error,
               mul_x, mul_y, mul_start
    );

endinterface

// File: rtl/radix_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or above ptr, wrapping.
module radix_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_idx,
    output logic             any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int             j;
            logic [IDW-1:0] jj;
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            jj = IDW'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt_idx = jj;
                gnt[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/radix_mul_arbiter.sv
// Shares one start/ready multiplier core among N_REQ requesters, round-robin,
// with a watchdog that turns a missing core ready into an error response.
module radix_mul_arbiter
    import radix_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    radix_mul_arbiter_if.slave  bus
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW  = $clog2(TIMEOUT);

    arb_state_e         state, state_nx;
    logic [IDW-1:0]     ptr, id_q, gnt_idx;
    logic [N_REQ-1:0]   gnt_oh;
    logic               any;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   x_q, y_q;
    logic [2*WIDTH-1:0] res_q;
    logic               err_q;
    logic               timeout;

    radix_rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign timeout = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // mul_ready takes precedence over an expiring watchdog in the same cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (any) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (bus.mul_ready || timeout) state_nx = RESP;
            RESP:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            id_q  <= '0;
            cnt   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (any) begin
                    x_q  <= bus.req_x[gnt_idx];
                    y_q  <= bus.req_y[gnt_idx];
                    id_q <= gnt_idx;
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (bus.mul_ready) begin
                        res_q <= bus.mul_result;
                        err_q <= 1'b0;
                    end else if (timeout) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: ptr <= (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
            endcase
        end
    end

    // Grant is only offered in IDLE and is held off while reset is asserted
    assign bus.req_ready  = (state == IDLE && !reset) ? gnt_oh : '0;
    assign bus.mul_start  = (state == ISSUE);
    assign bus.mul_x      = x_q;
    assign bus.mul_y      = y_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = (state == RESP) ? id_q  : '0;
    assign bus.rsp_result = (state == RESP) ? res_q : '0;
    assign bus.rsp_error  = (state == RESP) ? err_q : 1'b0;

endmodule
